// File: rtl/controller_mc.sv
// controller_mc: multicycle control FSM for an RV32 style core.
// Sequences fetch, decode, execute, an optional multicycle mul/div wait,
// data memory access, write-back and trap entry. Datapath strobes are
// combinational from the current state and the inputs. State, exception
// status, the memory wait counter and the retire counter are registered.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   instruction                currently latched instruction word
//   memory_ready/valid         memory handshake (accept / complete)
//   interrupted                pending enabled interrupt
//   address_low                execute result bits [1:0] (access address)
//   muldiv_done                multicycle unit result pulse
//   *_write_enable             datapath write strobes
//   memory_enable/command      memory request, 0=read 1=write
//   muldiv_start               start pulse to the multicycle unit
//   handle_trap / exit_trap    trap entry / MRET strobes
//   exception, exception_cause registered exception status
//   debug_state                current state encoding
//   retired_count              retired instruction counter (wraps)
//
// state      | meaning
// FETCH      | read instruction, wait for memory_valid
// DECODE     | take pending interrupt or proceed to execute
// EXECUTE    | latch ALU result, classify instruction
// MULDIV     | wait for multicycle unit
// MEMORY     | data load/store, alignment check on first cycle
// WRITE_BACK | update pc / register file, retire
// TRAP       | update pc to trap vector, no retire

module controller_mc #(
  parameter int unsigned MULDIV_ENABLE = 1,
  parameter int unsigned MEM_TIMEOUT   = 16,
  parameter int unsigned ALIGN_CHECK   = 1,
  parameter int unsigned RETIRE_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             instruction,
  input  logic                    memory_ready,
  input  logic                    memory_valid,
  input  logic                    interrupted,
  input  logic [1:0]              address_low,
  input  logic                    muldiv_done,
  output logic                    instruction_write_enable,
  output logic                    execute_result_write_enable,
  output logic                    load_memory_data_write_enable,
  output logic                    pc_write_enable,
  output logic                    register_file_write_enable,
  output logic                    memory_enable,
  output logic                    memory_command,
  output logic                    muldiv_start,
  output logic                    handle_trap,
  output logic                    exit_trap,
  output logic                    exception,
  output logic [30:0]             exception_cause,
  output logic [2:0]              debug_state,
  output logic [RETIRE_WIDTH-1:0] retired_count
);

  typedef enum logic [2:0] {
    ST_FETCH      = 3'd0,
    ST_DECODE     = 3'd1,
    ST_EXECUTE    = 3'd2,
    ST_MULDIV     = 3'd3,
    ST_MEMORY     = 3'd4,
    ST_WRITE_BACK = 3'd5,
    ST_TRAP       = 3'd6,
    ST_UNUSED     = 3'd7
  } state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);
  localparam bit MULDIV_ON = (MULDIV_ENABLE != 0);
  localparam bit ALIGN_ON  = (ALIGN_CHECK != 0);

  state_e                  state_q, state_d;
  logic                    exc_q, exc_d;
  logic [30:0]             cause_q, cause_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [RETIRE_WIDTH-1:0] retired_q, retired_d;

  // Instruction decode
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic is_load, is_store, is_calci, is_calcr, is_lui, is_auipc;
  logic is_jal, is_jalr, is_branch, is_fence, is_system;
  logic is_mop, is_ecall, is_mret, is_csr_rd, bad_shift, illegal;
  logic rd_writes, misaligned;
  logic [7:0] cnt_inc;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];

  assign is_load   = (opcode == 7'b0000011);
  assign is_store  = (opcode == 7'b0100011);
  assign is_calci  = (opcode == 7'b0010011);
  assign is_calcr  = (opcode == 7'b0110011);
  assign is_lui    = (opcode == 7'b0110111);
  assign is_auipc  = (opcode == 7'b0010111);
  assign is_jal    = (opcode == 7'b1101111);
  assign is_jalr   = (opcode == 7'b1100111);
  assign is_branch = (opcode == 7'b1100011);
  assign is_fence  = (opcode == 7'b0001111);
  assign is_system = (opcode == 7'b1110011);

  assign is_mop    = is_calcr && (funct7 == 7'b0000001);
  assign is_ecall  = (instruction == 32'h0000_0073);
  assign is_mret   = (instruction == 32'h3020_0073);
  // funct3=100 has no CSR meaning and is rejected as illegal
  assign is_csr_rd = is_system && (funct3 != 3'b000) && (funct3 != 3'b100);

  // SLLI needs funct7=0; SRLI/SRAI accept 0 or 0100000
  assign bad_shift = is_calci &&
                     (((funct3 == 3'b001) && (funct7 != 7'b0000000)) ||
                      ((funct3 == 3'b101) && (funct7 != 7'b0000000) &&
                       (funct7 != 7'b0100000)));

  assign illegal = !(is_load || is_store || is_calci || is_calcr || is_lui ||
                     is_auipc || is_jal || is_jalr || is_branch || is_fence ||
                     is_system) ||
                   bad_shift ||
                   (is_system && (funct3 == 3'b000) && !is_ecall && !is_mret) ||
                   (is_system && (funct3 == 3'b100)) ||
                   (is_mop && !MULDIV_ON);

  assign rd_writes = is_lui || is_auipc || is_jal || is_jalr || is_load ||
                     is_calci || is_calcr || is_csr_rd;

  assign misaligned = ALIGN_ON &&
                      (((funct3[1:0] == 2'b10) && (address_low != 2'b00)) ||
                       ((funct3[1:0] == 2'b01) && address_low[0]));

  assign cnt_inc = cnt_q + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      exc_q     <= 1'b0;
      cause_q   <= '0;
      cnt_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      exc_q     <= exc_d;
      cause_q   <= cause_d;
      cnt_q     <= cnt_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    exc_d     = exc_q;
    cause_d   = cause_q;
    cnt_d     = cnt_q;
    retired_d = retired_q;

    instruction_write_enable      = 1'b0;
    execute_result_write_enable   = 1'b0;
    load_memory_data_write_enable = 1'b0;
    pc_write_enable               = 1'b0;
    register_file_write_enable    = 1'b0;
    memory_enable                 = 1'b0;
    memory_command                = 1'b0;
    muldiv_start                  = 1'b0;
    handle_trap                   = 1'b0;
    exit_trap                     = 1'b0;

    case (state_q)
      ST_FETCH: begin
        memory_enable = memory_ready;
        if (memory_valid) begin
          instruction_write_enable = 1'b1;
          state_d = ST_DECODE;
        end else if (cnt_inc == TIMEOUT_C) begin
          state_d = ST_TRAP;
          exc_d   = 1'b1;
          cause_d = 31'd1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_DECODE: begin
        if (interrupted) begin
          state_d = ST_TRAP;
          exc_d   = 1'b0;
          cause_d = '0;
        end else begin
          state_d = ST_EXECUTE;
        end
      end

      ST_EXECUTE: begin
        execute_result_write_enable = 1'b1;
        if (illegal) begin
          state_d = ST_TRAP;
          exc_d   = 1'b1;
          cause_d = 31'd2;
        end else if (is_ecall) begin
          state_d = ST_TRAP;
          exc_d   = 1'b1;
          cause_d = 31'd11;
        end else if (is_load || is_store) begin
          state_d = ST_MEMORY;
          cnt_d   = '0;
        end else if (is_mop) begin
          state_d      = ST_MULDIV;
          muldiv_start = 1'b1;
        end else begin
          state_d = ST_WRITE_BACK;
        end
      end

      ST_MULDIV: begin
        if (muldiv_done) begin
          execute_result_write_enable = 1'b1;
          state_d = ST_WRITE_BACK;
        end
      end

      ST_MEMORY: begin
        // counter is still zero only on the first MEMORY cycle
        if ((cnt_q == 8'd0) && misaligned) begin
          state_d = ST_TRAP;
          exc_d   = 1'b1;
          cause_d = is_load ? 31'd4 : 31'd6;
        end else begin
          memory_enable  = memory_ready;
          memory_command = is_store;
          if (memory_valid) begin
            load_memory_data_write_enable = is_load;
            state_d = ST_WRITE_BACK;
          end else if (cnt_inc == TIMEOUT_C) begin
            state_d = ST_TRAP;
            exc_d   = 1'b1;
            cause_d = is_load ? 31'd5 : 31'd7;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      ST_WRITE_BACK: begin
        pc_write_enable            = 1'b1;
        register_file_write_enable = rd_writes;
        exit_trap                  = is_mret;
        retired_d = retired_q + RETIRE_WIDTH'(1);
        state_d   = ST_FETCH;
        cnt_d     = '0;
        exc_d     = 1'b0;
        cause_d   = '0;
      end

      ST_TRAP: begin
        pc_write_enable = 1'b1;
        handle_trap     = 1'b1;
        state_d = ST_FETCH;
        cnt_d   = '0;
        exc_d   = 1'b0;
        cause_d = '0;
      end

      default: begin
        state_d = ST_FETCH;
        cnt_d   = '0;
        exc_d   = 1'b0;
        cause_d = '0;
      end
    endcase

    // strobes must be quiet while reset is held, even though FETCH would
    // otherwise forward memory_ready
    if (reset) begin
      instruction_write_enable      = 1'b0;
      execute_result_write_enable   = 1'b0;
      load_memory_data_write_enable = 1'b0;
      pc_write_enable               = 1'b0;
      register_file_write_enable    = 1'b0;
      memory_enable                 = 1'b0;
      memory_command                = 1'b0;
      muldiv_start                  = 1'b0;
      handle_trap                   = 1'b0;
      exit_trap                     = 1'b0;
    end
  end

  assign exception       = exc_q;
  assign exception_cause = cause_q;
  assign debug_state     = state_q;
  assign retired_count   = retired_q;

endmodule

// File: tb/tb_controller_mc.sv
// Directed bench for controller_mc. dut_a uses default parameters;
// dut_b shares all inputs and runs with mul/div disabled, a 3-cycle memory
// timeout, no alignment check and a 4-bit retire counter.

module tb_controller_mc;

  localparam logic [9:0] S_IWE = 10'b10_0000_0000;
  localparam logic [9:0] S_EWE = 10'b01_0000_0000;
  localparam logic [9:0] S_LWE = 10'b00_1000_0000;
  localparam logic [9:0] S_PC  = 10'b00_0100_0000;
  localparam logic [9:0] S_RF  = 10'b00_0010_0000;
  localparam logic [9:0] S_MEN = 10'b00_0001_0000;
  localparam logic [9:0] S_CMD = 10'b00_0000_1000;
  localparam logic [9:0] S_MST = 10'b00_0000_0100;
  localparam logic [9:0] S_HT  = 10'b00_0000_0010;
  localparam logic [9:0] S_XT  = 10'b00_0000_0001;

  localparam logic [31:0] I_ADDI   = 32'h0050_0093;
  localparam logic [31:0] I_MUL    = 32'h0220_81B3;
  localparam logic [31:0] I_LW     = 32'h0000_A283;
  localparam logic [31:0] I_SW     = 32'h0020_A023;
  localparam logic [31:0] I_SH     = 32'h0020_9023;
  localparam logic [31:0] I_ECALL  = 32'h0000_0073;
  localparam logic [31:0] I_MRET   = 32'h3020_0073;
  localparam logic [31:0] I_EBREAK = 32'h0010_0073;
  localparam logic [31:0] I_BADSH  = 32'h4010_9093;
  localparam logic [31:0] I_JUNK   = 32'hFFFF_FFFF;

  logic        clk, reset;
  logic [31:0] instruction;
  logic        memory_ready, memory_valid, interrupted, muldiv_done;
  logic [1:0]  address_low;

  logic a_iwe, a_ewe, a_lwe, a_pc, a_rf, a_men, a_cmd, a_mst, a_ht, a_xt, a_exc;
  logic [30:0] a_cause;
  logic [2:0]  a_state;
  logic [31:0] a_ret;
  logic b_iwe, b_ewe, b_lwe, b_pc, b_rf, b_men, b_cmd, b_mst, b_ht, b_xt, b_exc;
  logic [30:0] b_cause;
  logic [2:0]  b_state;
  logic [3:0]  b_ret;
  logic [9:0]  a_sb;

  assign a_sb = {a_iwe, a_ewe, a_lwe, a_pc, a_rf, a_men, a_cmd, a_mst, a_ht, a_xt};

  int total = 0;
  int bad   = 0;

  controller_mc dut_a (
    .clk(clk), .reset(reset), .instruction(instruction),
    .memory_ready(memory_ready), .memory_valid(memory_valid),
    .interrupted(interrupted), .address_low(address_low),
    .muldiv_done(muldiv_done),
    .instruction_write_enable(a_iwe), .execute_result_write_enable(a_ewe),
    .load_memory_data_write_enable(a_lwe), .pc_write_enable(a_pc),
    .register_file_write_enable(a_rf), .memory_enable(a_men),
    .memory_command(a_cmd), .muldiv_start(a_mst), .handle_trap(a_ht),
    .exit_trap(a_xt), .exception(a_exc), .exception_cause(a_cause),
    .debug_state(a_state), .retired_count(a_ret)
  );

  controller_mc #(
    .MULDIV_ENABLE(0), .MEM_TIMEOUT(3), .ALIGN_CHECK(0), .RETIRE_WIDTH(4)
  ) dut_b (
    .clk(clk), .reset(reset), .instruction(instruction),
    .memory_ready(memory_ready), .memory_valid(memory_valid),
    .interrupted(interrupted), .address_low(address_low),
    .muldiv_done(muldiv_done),
    .instruction_write_enable(b_iwe), .execute_result_write_enable(b_ewe),
    .load_memory_data_write_enable(b_lwe), .pc_write_enable(b_pc),
    .register_file_write_enable(b_rf), .memory_enable(b_men),
    .memory_command(b_cmd), .muldiv_start(b_mst), .handle_trap(b_ht),
    .exit_trap(b_xt), .exception(b_exc), .exception_cause(b_cause),
    .debug_state(b_state), .retired_count(b_ret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // apply one cycle of inputs, check dut_a state and strobes, advance
  task automatic cyc(input string tag, input logic v, input logic intr,
                     input logic done, input logic [2:0] exp_st,
                     input logic [9:0] exp_sb);
    memory_valid = v;
    interrupted  = intr;
    muldiv_done  = done;
    #1;
    check_eq({tag, "/state"}, 64'(a_state), 64'(exp_st));
    check_eq({tag, "/strobes"}, 64'(a_sb), 64'(exp_sb));
    @(posedge clk);
    #1;
  endtask

  task automatic fde(input string tag, input logic [31:0] instr, input logic [9:0] exe_sb);
    instruction = instr;
    cyc({tag, "_f"}, 1'b1, 1'b0, 1'b0, 3'd0, S_IWE | S_MEN);
    cyc({tag, "_d"}, 1'b0, 1'b0, 1'b0, 3'd1, 10'd0);
    cyc({tag, "_e"}, 1'b0, 1'b0, 1'b0, 3'd2, exe_sb);
  endtask

  task automatic exec_trap(input string tag, input logic [31:0] instr,
                           input logic [30:0] cause);
    fde(tag, instr, S_EWE);
    check_eq({tag, "_exc"}, 64'(a_exc), 64'd1);
    check_eq({tag, "_cause"}, 64'(a_cause), 64'(cause));
    cyc({tag, "_trap"}, 1'b0, 1'b0, 1'b0, 3'd6, S_PC | S_HT);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    instruction = 32'h0;
    memory_ready = 1'b1;
    memory_valid = 1'b0;
    interrupted = 1'b0;
    muldiv_done = 1'b0;
    address_low = 2'b00;
    #2;
    check_eq("rst_state", 64'(a_state), 64'd0);
    check_eq("rst_strobes", 64'(a_sb), 64'd0);
    check_eq("rst_exc", 64'(a_exc), 64'd0);
    check_eq("rst_cause", 64'(a_cause), 64'd0);
    check_eq("rst_ret", 64'(a_ret), 64'd0);
    check_eq("rst_b_men", 64'(b_men), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // ADDI with fetch completing on the third FETCH cycle
    instruction = I_ADDI;
    cyc("addi_f0", 1'b0, 1'b0, 1'b0, 3'd0, S_MEN);
    cyc("addi_f1", 1'b0, 1'b0, 1'b0, 3'd0, S_MEN);
    cyc("addi_f2", 1'b1, 1'b0, 1'b0, 3'd0, S_IWE | S_MEN);
    cyc("addi_d",  1'b0, 1'b0, 1'b0, 3'd1, 10'd0);
    cyc("addi_e",  1'b0, 1'b0, 1'b0, 3'd2, S_EWE);
    cyc("addi_wb", 1'b0, 1'b0, 1'b0, 3'd5, S_PC | S_RF);
    check_eq("addi_back_fetch", 64'(a_state), 64'd0);
    check_eq("addi_ret", 64'(a_ret), 64'd1);

    // MUL: five MULDIV cycles on dut_a, illegal then fetch timeout on dut_b
    fde("mul", I_MUL, S_EWE | S_MST);
    check_eq("b_mul_state", 64'(b_state), 64'd6);
    check_eq("b_mul_exc", 64'(b_exc), 64'd1);
    check_eq("b_mul_cause", 64'(b_cause), 64'd2);
    for (int i = 0; i < 4; i++) cyc("mul_wait", 1'b0, 1'b0, 1'b0, 3'd3, 10'd0);
    check_eq("b_fetch_to_state", 64'(b_state), 64'd6);
    check_eq("b_fetch_to_cause", 64'(b_cause), 64'd1);
    cyc("mul_done", 1'b0, 1'b0, 1'b1, 3'd3, S_EWE);
    cyc("mul_wb", 1'b0, 1'b0, 1'b0, 3'd5, S_PC | S_RF);
    check_eq("mul_ret", 64'(a_ret), 64'd2);

    // LW to address ending in 2: load misaligned, no memory request
    address_low = 2'd2;
    fde("lw_mis", I_LW, S_EWE);
    cyc("lw_mis_mem", 1'b0, 1'b0, 1'b0, 3'd4, 10'd0);
    check_eq("lw_mis_exc", 64'(a_exc), 64'd1);
    check_eq("lw_mis_cause", 64'(a_cause), 64'd4);
    cyc("lw_mis_trap", 1'b0, 1'b0, 1'b0, 3'd6, S_PC | S_HT);
    check_eq("lw_mis_exc_clr", 64'(a_exc), 64'd0);
    check_eq("lw_mis_cause_clr", 64'(a_cause), 64'd0);
    check_eq("lw_mis_ret", 64'(a_ret), 64'd2);

    // SH to odd address: store misaligned
    address_low = 2'd3;
    fde("sh_mis", I_SH, S_EWE);
    cyc("sh_mis_mem", 1'b0, 1'b0, 1'b0, 3'd4, 10'd0);
    check_eq("sh_mis_cause", 64'(a_cause), 64'd6);
    cyc("sh_mis_trap", 1'b0, 1'b0, 1'b0, 3'd6, S_PC | S_HT);

    // SW never completes: 16 MEMORY cycles then store access fault
    address_low = 2'd0;
    fde("sw_to", I_SW, S_EWE);
    for (int i = 0; i < 16; i++) cyc("sw_to_mem", 1'b0, 1'b0, 1'b0, 3'd4, S_MEN | S_CMD);
    check_eq("sw_to_exc", 64'(a_exc), 64'd1);
    check_eq("sw_to_cause", 64'(a_cause), 64'd7);
    cyc("sw_to_trap", 1'b0, 1'b0, 1'b0, 3'd6, S_PC | S_HT);
    check_eq("sw_to_ret", 64'(a_ret), 64'd2);

    // SW completing on the 16th cycle is still a success
    fde("sw_edge", I_SW, S_EWE);
    for (int i = 0; i < 15; i++) cyc("sw_edge_mem", 1'b0, 1'b0, 1'b0, 3'd4, S_MEN | S_CMD);
    cyc("sw_edge_ok", 1'b1, 1'b0, 1'b0, 3'd4, S_MEN | S_CMD);
    cyc("sw_edge_wb", 1'b0, 1'b0, 1'b0, 3'd5, S_PC);
    check_eq("sw_edge_ret", 64'(a_ret), 64'd3);

    // aligned LW completing immediately
    fde("lw_ok", I_LW, S_EWE);
    cyc("lw_ok_mem", 1'b1, 1'b0, 1'b0, 3'd4, S_MEN | S_LWE);
    cyc("lw_ok_wb", 1'b0, 1'b0, 1'b0, 3'd5, S_PC | S_RF);
    check_eq("lw_ok_ret", 64'(a_ret), 64'd4);

    // interrupt taken in DECODE
    instruction = I_ADDI;
    cyc("int_f", 1'b1, 1'b0, 1'b0, 3'd0, S_IWE | S_MEN);
    cyc("int_d", 1'b0, 1'b1, 1'b0, 3'd1, 10'd0);
    check_eq("int_exc", 64'(a_exc), 64'd0);
    cyc("int_trap", 1'b0, 1'b0, 1'b0, 3'd6, S_PC | S_HT);
    check_eq("int_ret", 64'(a_ret), 64'd4);

    // synchronous traps raised from EXECUTE
    exec_trap("ecall", I_ECALL, 31'd11);
    exec_trap("junk", I_JUNK, 31'd2);
    exec_trap("badsh", I_BADSH, 31'd2);
    exec_trap("ebreak", I_EBREAK, 31'd2);

    // MRET retires with exit_trap and no register write
    fde("mret", I_MRET, S_EWE);
    cyc("mret_wb", 1'b0, 1'b0, 1'b0, 3'd5, S_PC | S_XT);
    check_eq("mret_ret", 64'(a_ret), 64'd5);

    // reset in the middle of MULDIV aborts immediately
    fde("mul_rst", I_MUL, S_EWE | S_MST);
    cyc("mul_rst_w", 1'b0, 1'b0, 1'b0, 3'd3, 10'd0);
    reset = 1'b1;
    muldiv_done = 1'b1;
    #1;
    check_eq("mul_rst_state", 64'(a_state), 64'd0);
    check_eq("mul_rst_strobes", 64'(a_sb), 64'd0);
    check_eq("mul_rst_ret", 64'(a_ret), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    muldiv_done = 1'b0;

    // sixteen retirements wrap the 4-bit counter of dut_b
    pulse_reset();
    instruction = I_ADDI;
    for (int k = 1; k <= 16; k++) begin
      cyc("wrap_f", 1'b1, 1'b0, 1'b0, 3'd0, S_IWE | S_MEN);
      cyc("wrap_d", 1'b0, 1'b0, 1'b0, 3'd1, 10'd0);
      cyc("wrap_e", 1'b0, 1'b0, 1'b0, 3'd2, S_EWE);
      cyc("wrap_wb", 1'b0, 1'b0, 1'b0, 3'd5, S_PC | S_RF);
      if (k == 15) check_eq("wrap_b_15", 64'(b_ret), 64'd15);
    end
    check_eq("wrap_b_0", 64'(b_ret), 64'd0);
    check_eq("wrap_a_16", 64'(a_ret), 64'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/controller_mc.md
CONTROLLER_MC -- requirements
Module: controller_mc

Interface
REQ-001 Parameter MULDIV_ENABLE, default 1, meaning: M-extension (funct7=0000001 on CALCR) executed via multicycle unit; 0 makes it illegal.
REQ-002 Parameter MEM_TIMEOUT, default 16, meaning: max cycles waiting for memory_valid before access fault; legal range 1..255.
REQ-003 Parameter ALIGN_CHECK, default 1, meaning: raise misaligned exceptions for load/store.
REQ-004 Parameter RETIRE_WIDTH, default 32, meaning: width of retired-instruction counter.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  reset; one clock, asynchronous, active-high.
REQ-007 instruction  in  32  current latched instruction.
REQ-008 memory_ready  in  1  memory can accept a request this cycle.
REQ-009 memory_valid  in  1  memory request completed this cycle.
REQ-010 interrupted  in  1  pending enabled interrupt.
REQ-011 address_low  in  2  bits [1:0] of the execute result register.
REQ-012 muldiv_done  in  1  multicycle unit result ready (one-cycle pulse).
REQ-013 instruction_write_enable, execute_result_write_enable, load_memory_data_write_enable, pc_write_enable, register_file_write_enable  out  1 each  datapath write strobes.
REQ-014 memory_enable  out  1  memory request; memory_command  out  1  0=read, 1=write.
REQ-015 muldiv_start  out  1  one-cycle start pulse to multicycle unit.
REQ-016 handle_trap, exit_trap  out  1 each  trap entry / MRET strobes.
REQ-017 exception  out  1; exception_cause  out  31  registered cause code.
REQ-018 debug_state  out  3  current state encoding.
REQ-019 retired_count  out  RETIRE_WIDTH  instructions retired.

Function
REQ-020 States and encodings: FETCH=0, DECODE=1, EXECUTE=2, MULDIV=3, MEMORY=4, WRITE_BACK=5, TRAP=6; 7 unreachable, returns to FETCH.
REQ-021 FETCH: memory_enable=memory_ready, memory_command=0; on memory_valid assert instruction_write_enable, go DECODE; exception and cause cleared on entry cycle.
REQ-022 DECODE: go TRAP if interrupted, else EXECUTE.
REQ-023 EXECUTE: assert execute_result_write_enable; LOAD/STORE -> MEMORY; M-op with MULDIV_ENABLE=1 -> MULDIV with muldiv_start=1 for exactly that cycle; others -> WRITE_BACK.
REQ-024 MULDIV: hold until muldiv_done, then assert execute_result_write_enable and go WRITE_BACK; muldiv_start stays 0.
REQ-025 MEMORY: when ALIGN_CHECK=1, on the first cycle check funct3[1:0]: 10 with address_low!=0, or 01 with address_low[0]=1, -> TRAP with cause 4 (load) or 6 (store), no memory_enable issued.
REQ-026 MEMORY otherwise: memory_enable=memory_ready, memory_command=1 for STORE else 0; on memory_valid, LOAD asserts load_memory_data_write_enable, go WRITE_BACK.
REQ-027 Wait counter (8 bits) clears on entry to FETCH or MEMORY, increments each cycle memory_valid=0; when it equals MEM_TIMEOUT with memory_valid=0, go TRAP with cause 1 (fetch), 5 (load) or 7 (store).
REQ-028 memory_valid in the same cycle as counter reaching MEM_TIMEOUT counts as success.
REQ-029 Exception causes: illegal instruction 2 (unknown opcode, bad shift funct7, SYSTEM funct3=0 other than ECALL/MRET, M-op with MULDIV_ENABLE=0), ECALL 11; each -> TRAP from EXECUTE.
REQ-030 WRITE_BACK: pc_write_enable=1; register_file_write_enable for LUI, AUIPC, JAL, JALR, LOAD, CALCI, CALCR, and CSR ops with rd-writing funct3; MRET asserts exit_trap; increment retired_count; go FETCH.
REQ-031 TRAP: pc_write_enable=1, handle_trap=1, retired_count unchanged, go FETCH; exception=1 only for synchronous causes, 0 for interrupts.
REQ-032 retired_count wraps modulo 2^RETIRE_WIDTH.
REQ-033 State, exception, cause, counters are registered; all strobes are combinational from state and inputs.

Reset
REQ-034 On reset assertion, immediately: state=FETCH, exception=0, exception_cause=0, wait counter=0, retired_count=0; all strobes 0.
REQ-035 Reset asserted mid-MEMORY or mid-MULDIV aborts the operation with no write-back and no retire.

Verification
REQ-036 ADDI fetched with valid after 2 cycles -> states 0,0,0,1,2,5,0; register_file_write_enable once; retired_count 0->1.
REQ-037 MUL, MULDIV_ENABLE=1, muldiv_done 5 cycles after start -> muldiv_start single pulse, 5 cycles in state 3, retire; with MULDIV_ENABLE=0 -> TRAP, cause 2.
REQ-038 LW with address_low=2 -> TRAP from MEMORY, exception=1, cause=4, memory_enable never 1.
REQ-039 SW with memory_valid never asserted, MEM_TIMEOUT=16 -> TRAP after 16 MEMORY cycles, cause 7.
REQ-040 interrupted=1 in DECODE -> TRAP, handle_trap=1, exception=0, retired_count unchanged.
REQ-041 RETIRE_WIDTH=4, 16 retirements -> retired_count wraps to 0; reset mid-MULDIV -> state 0 same cycle.
